dcache_direct: RTL

Direct-mapped, write-back, write-allocate data cache that serves the CPU's data-memory port. It responds to the CPU's `READ`/`WRITE` requests and stalls the CPU with `BUSYWAIT` on misses. It also initiates block transfers to the 32-bit-wide main data memory. It holds 8 lines of 4 bytes each and sits between the CPU's ALU-result address / register-file write-data path and the main memory model.

---
 rtl/dcache_direct.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dcache_direct.sv
// dcache_direct: 8-line x 4-byte direct-mapped, write-back, write-allocate
// data cache between the CPU data port and a 32-bit main memory.
//
// Address split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0].
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   READ, WRITE       CPU load/store request (level, held while BUSYWAIT)
//   ADDRESS           CPU byte address
//   WRITEDATA         CPU store byte
//   READDATA          load byte (8'h00 unless a read hits in IDLE)
//   BUSYWAIT          CPU stall
//   MEM_READ          block fetch request
//   MEM_WRITE         block write-back request
//   MEM_ADDRESS       block address {tag,index}
//   MEM_WRITEDATA     write-back block, byte 0 in [7:0]
//   MEM_READDATA      fetched block, byte 0 in [7:0]
//   MEM_BUSYWAIT      memory busy; transfer completes when sampled low
//   HIT_COUNT,        (only with DCACHE_STATS_EN) saturating counts of
//   MISS_COUNT        first-lookup hits and of miss-handling starts
//
// Optional feature macro: DCACHE_STATS_EN
module dcache_direct (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
`ifdef DCACHE_STATS_EN
  input  logic        MEM_BUSYWAIT,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`else
  input  logic        MEM_BUSYWAIT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WRITE,
    S_MEM_READ,
    S_UPDATE
  } state_t;

  state_t      state_q;
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];

  logic        mem_read_q;
  logic        mem_write_q;
  logic [5:0]  mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [2:0]  addr_tag;
  logic [2:0]  addr_idx;
  logic [4:0]  byte_lsb;
  logic        req;
  logic        hit;

  assign addr_tag = ADDRESS[7:5];
  assign addr_idx = ADDRESS[4:2];
  assign byte_lsb = {ADDRESS[1:0], 3'b000};
  assign req      = READ | WRITE;
  assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Hits are answered combinationally so the CPU sees no stall.
  assign BUSYWAIT = (state_q != S_IDLE) || (req && !hit);
  assign READDATA = (state_q == S_IDLE && READ && hit) ?
                    data_q[addr_idx][byte_lsb +: 8] : 8'h00;

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

  // Memory request outputs are loaded on the edge that enters the state
  // that owns them, so they stay glitch-free registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              if (WRITE) begin
                data_q[addr_idx][byte_lsb +: 8] <= WRITEDATA;
                dirty_q[addr_idx]               <= 1'b1;
              end
            end else if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
              state_q     <= S_MEM_WRITE;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[addr_idx], addr_idx};
              mem_wdata_q <= data_q[addr_idx];
            end else begin
              state_q    <= S_MEM_READ;
              mem_read_q <= 1'b1;
              mem_addr_q <= ADDRESS[7:2];
            end
          end
        end
        S_MEM_WRITE: begin
          if (!MEM_BUSYWAIT) begin
            state_q     <= S_MEM_READ;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= ADDRESS[7:2];
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            state_q    <= S_UPDATE;
            mem_read_q <= 1'b0;
          end
        end
        S_UPDATE: begin
          data_q[addr_idx]  <= MEM_READDATA;
          tag_q[addr_idx]   <= addr_tag;
          valid_q[addr_idx] <= 1'b1;
          dirty_q[addr_idx] <= 1'b0;
          state_q           <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        refill_q;

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;

  // refill_q marks the IDLE cycle right after UPDATE, whose hit is the
  // completion of an already-counted miss rather than a fresh hit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      refill_q <= (state_q == S_UPDATE);
      if (state_q == S_IDLE && req) begin
        if (hit) begin
          if (!refill_q && hit_cnt_q != 16'hFFFF)
            hit_cnt_q <= hit_cnt_q + 16'd1;
        end else if (miss_cnt_q != 16'hFFFF) begin
          miss_cnt_q <= miss_cnt_q + 16'd1;
        end
      end
    end
  end
`endif

endmodule
